// File: rtl/dm_wait_ctrl.sv
// dm_wait_ctrl: word-organised data memory with byte-lane store merging and a
// fixed-latency req/resp handshake for the MEM stage.
//
// - A request is accepted in IDLE. The FSM then spends WAIT_CYCLES cycles in
//   WAIT and performs the access in RESP, where resp_valid pulses for one cycle.
// - rdata returns the full aligned word. Loads return the word before the
//   access; stores return the word after the merge.
// - Configuration macro DM_WRITE_TRACE_EN: when it is defined, every
//   successful store prints one trace line. When it is undefined, the block
//   prints nothing and is otherwise identical.
module dm_wait_ctrl #(
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        we,
    input  logic [1:0]  store_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        busy
);

    localparam int        DEPTH    = 1 << AW;
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    // store_sel encodings
    localparam logic [1:0] SEL_SW  = 2'd0;
    localparam logic [1:0] SEL_SH  = 2'd1;
    localparam logic [1:0] SEL_SB  = 2'd2;
    localparam logic [1:0] SEL_RSV = 2'd3;

    // The wait counter is 4 bits wide, so larger values cannot be represented.
    if (WAIT_CYCLES > 15) begin : g_wait_range_err
        $error("dm_wait_ctrl: WAIT_CYCLES=%0d exceeds the maximum of 15", WAIT_CYCLES);
    end
    if (AW < 1 || AW > 29) begin : g_aw_range_err
        $error("dm_wait_ctrl: AW=%0d outside supported range 1..29", AW);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Request fields captured at accept. The access only ever uses these copies.
    logic        we_q;
    logic [1:0]  sel_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;

    logic [31:0] mem_q [DEPTH];

    logic          accept;
    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic [31:0]   merged;
    logic          out_of_range;
    logic          misaligned;
    logic          reserved_sel;
    logic          acc_err;
    logic          do_write;

    // Error classification and word lookup, based on the latched request.
    assign word_idx     = addr_q[AW+1:2];
    assign cur_word     = mem_q[word_idx];
    assign out_of_range = |addr_q[31:AW+2];
    assign misaligned   = we_q && (((sel_q == SEL_SW) && (addr_q[1:0] != 2'b00)) ||
                                   ((sel_q == SEL_SH) && addr_q[0]));
    assign reserved_sel = we_q && (sel_q == SEL_RSV);
    assign acc_err      = out_of_range || misaligned || reserved_sel;
    assign do_write     = (state_q == S_RESP) && we_q && !acc_err;
    assign accept       = req_valid && req_ready;
    assign busy         = ~req_ready;

    // Byte-lane merge of the store data into the addressed word.
    always_comb begin
        // NOTE: every signal written in this block gets a default first.
        // Without the default, some case paths would leave the signal unassigned,
        // and synthesis would infer a latch to hold its old value.
        merged = cur_word;
        case (sel_q)
            SEL_SW: merged = wdata_q;
            SEL_SH: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            SEL_SB: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default: merged = cur_word;
        endcase
    end

    // Next-state and handshake outputs for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rdata      = '0;
        align_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                align_err  = acc_err;
                if (!acc_err) rdata = we_q ? merged : cur_word;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and wait counter. Reset discards any request in flight.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments (<=).
        // This makes every register sample its pre-edge inputs, so the
        // registers update together and do not depend on statement order.
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields on accept. At all other times inputs are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
        end else if (accept) begin
            we_q    <= we;
            sel_q   <= store_sel;
            addr_q  <= addr;
            wdata_q <= wdata;
            pc_q    <= pc;
        end
    end

    // Memory array. A successful store writes the merged word on the edge that leaves RESP.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: this memory is reset on purpose. Every word must read back as 0
        // after reset, so the array is built from resettable flops and cannot
        // be mapped onto a RAM macro.
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_write) begin
            mem_q[word_idx] <= merged;
        end
    end

`ifdef DM_WRITE_TRACE_EN
    // Write trace: one line per committed store, showing the full merged word.
    always @(posedge clk) begin
        if (reset && do_write)
            $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, merged);
    end
`else
    // The PC is only consumed by the trace. It is folded here so that the
    // build without the trace stays identical apart from the trace output.
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_dm_wait_ctrl.sv
// Self-checking bench for dm_wait_ctrl.
// Three instances run with WAIT_CYCLES = 0, 1 and 3, and each has its own reset.
// Expected values come from a byte-addressed reference memory per instance.
module tb_dm_wait_ctrl;

    localparam int AW        = 10;
    localparam int MEM_BYTES = 4 << AW;
    localparam int NDUT      = 3;

    function automatic int wait_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 1 : 3;
    endfunction

    logic        clk;
    logic        rst_v       [NDUT];
    logic        req_valid_v [NDUT];
    logic        req_ready_v [NDUT];
    logic        we_v        [NDUT];
    logic [1:0]  sel_v       [NDUT];
    logic [31:0] addr_v      [NDUT];
    logic [31:0] wdata_v     [NDUT];
    logic [31:0] pc_v        [NDUT];
    logic        resp_v      [NDUT];
    logic [31:0] rdata_v     [NDUT];
    logic        err_v       [NDUT];
    logic        busy_v      [NDUT];

    // Reference memory: one flat byte array per instance.
    logic [7:0] mbytes [NDUT][MEM_BYTES];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dm_wait_ctrl #(.AW(AW), .WAIT_CYCLES(wait_of(g))) u_dut (
            .clk       (clk),
            .reset     (rst_v[g]),
            .req_valid (req_valid_v[g]),
            .req_ready (req_ready_v[g]),
            .we        (we_v[g]),
            .store_sel (sel_v[g]),
            .addr      (addr_v[g]),
            .wdata     (wdata_v[g]),
            .pc        (pc_v[g]),
            .resp_valid(resp_v[g]),
            .rdata     (rdata_v[g]),
            .align_err (err_v[g]),
            .busy      (busy_v[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int k, input int base);
        return {mbytes[k][base+3], mbytes[k][base+2], mbytes[k][base+1], mbytes[k][base]};
    endfunction

    task automatic model_clear(input int k);
        for (int i = 0; i < MEM_BYTES; i++) mbytes[k][i] = 8'h00;
    endtask

    // Behavioural access. A store writes nb bytes little-endian at the byte
    // address, after checks for range, natural alignment and the reserved
    // store size.
    task automatic model_access(input int k, input logic w, input logic [1:0] sel,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] exp_rd, output logic exp_err);
        int  nb;
        bit  in_range;
        in_range = (a < MEM_BYTES);
        exp_rd   = 32'h0;
        if (!w) begin
            exp_err = !in_range;
            if (in_range) exp_rd = model_word(k, int'(a) & ~3);
        end else begin
            nb      = (sel == 2'd0) ? 4 : (sel == 2'd1) ? 2 : (sel == 2'd2) ? 1 : 0;
            exp_err = !in_range || (nb == 0) || ((a % nb) != 0);
            if (!exp_err) begin
                for (int i = 0; i < nb; i++) mbytes[k][int'(a) + i] = wd[8*i +: 8];
                exp_rd = model_word(k, int'(a) & ~3);
            end
        end
    endtask

    // Issue one request to instance k. Check latency, the busy window, the
    // response and the single-cycle pulse.
    task automatic do_req(input int k, input logic w, input logic [1:0] sel,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] obs_rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        bit          seen;
        model_access(k, w, sel, a, wd, exp_rd, exp_err);
        @(negedge clk);
        check("ready_in_idle", 32'(req_ready_v[k]), 32'd1);
        req_valid_v[k] = 1'b1;
        we_v[k]        = w;
        sel_v[k]       = sel;
        addr_v[k]      = a;
        wdata_v[k]     = wd;
        pc_v[k]        = $urandom;
        @(posedge clk);
        #1;
        // Scramble the inputs after accept. The response must not depend on them.
        req_valid_v[k] = 1'b0;
        we_v[k]        = ~w;
        sel_v[k]       = 2'($urandom_range(0, 3));
        addr_v[k]      = $urandom;
        wdata_v[k]     = $urandom;
        seen   = 1'b0;
        n      = 0;
        obs_rd = 'x;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (resp_v[k]) seen = 1'b1;
            else check("ready_low_in_wait", 32'(req_ready_v[k]), 32'd0);
        end
        check("resp_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(n), 32'(wait_of(k) + 1));
            check("rdata", rdata_v[k], exp_rd);
            check("align_err", 32'(err_v[k]), 32'(exp_err));
            check("busy_in_resp", 32'(busy_v[k]), 32'd1);
            obs_rd = rdata_v[k];
            @(negedge clk);
            check("resp_one_cycle", 32'(resp_v[k]), 32'd0);
            check("ready_after_resp", 32'(req_ready_v[k]), 32'd1);
        end
    endtask

    // Hold req_valid high for four loads from 0x20. Check ready/resp_valid every
    // cycle against an accept-relative timeline, and check the response spacing.
    task automatic held_loads(input int k);
        int          w;
        int          acc;
        int          since;
        int          nresp;
        int          extra;
        time         t_prev;
        bit          exp_ready;
        bit          exp_resp;
        logic [31:0] exp_rd;
        logic        exp_err;
        w = wait_of(k);
        acc = 0; since = 0; nresp = 0; t_prev = 0;
        model_access(k, 1'b0, 2'd0, 32'h20, 32'h0, exp_rd, exp_err);
        @(negedge clk);
        we_v[k] = 1'b0; sel_v[k] = 2'd0; addr_v[k] = 32'h20; req_valid_v[k] = 1'b1;
        for (int c = 0; c < 80 && nresp < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (acc > 0) since++;
            exp_ready = (acc == 0) || (since >= w + 2);
            exp_resp  = (acc > 0) && (since == w + 1);
            check($sformatf("held_ready_w%0d", w), 32'(req_ready_v[k]), 32'(exp_ready));
            check($sformatf("held_resp_w%0d", w), 32'(resp_v[k]), 32'(exp_resp));
            if (resp_v[k]) begin
                nresp++;
                check($sformatf("held_rdata_w%0d", w), rdata_v[k], exp_rd);
                if (nresp > 1)
                    check($sformatf("spacing_w%0d", w), 32'((($time - t_prev) / 10)), 32'(w + 2));
                t_prev = $time;
            end
            if (req_valid_v[k] && exp_ready && acc < 4) begin
                acc++;
                since = 0;
                if (acc == 4) begin
                    @(posedge clk);
                    #1 req_valid_v[k] = 1'b0;
                end
            end
        end
        check($sformatf("held_resp_count_w%0d", w), 32'(nresp), 32'd4);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_v[k]) extra++;
        end
        check($sformatf("held_no_extra_w%0d", w), 32'(extra), 32'd0);
    endtask

    initial begin : main
        logic [31:0] rd;
        logic        w;
        logic [1:0]  sel;
        logic [31:0] a;
        int          pulses;

        for (int k = 0; k < NDUT; k++) begin
            rst_v[k] = 1'b0; req_valid_v[k] = 1'b0; we_v[k] = 1'b0; sel_v[k] = 2'd0;
            addr_v[k] = '0; wdata_v[k] = '0; pc_v[k] = '0;
            model_clear(k);
        end

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("rst_ready", 32'(req_ready_v[k]), 32'd1);
            check("rst_resp", 32'(resp_v[k]), 32'd0);
            check("rst_rdata", rdata_v[k], 32'd0);
            check("rst_err", 32'(err_v[k]), 32'd0);
            check("rst_busy", 32'(busy_v[k]), 32'd0);
        end
        for (int k = 0; k < NDUT; k++) rst_v[k] = 1'b1;

        // Directed sequence on the WAIT_CYCLES=1 instance.
        do_req(1, 1'b0, 2'd0, 32'h10, 32'h0, rd);
        check("lw_after_reset", rd, 32'h0);
        do_req(1, 1'b1, 2'd0, 32'h20, 32'h1234_5678, rd);
        do_req(1, 1'b1, 2'd2, 32'h21, 32'h0000_00AB, rd);
        do_req(1, 1'b1, 2'd1, 32'h22, 32'h0000_CDEF, rd);
        do_req(1, 1'b0, 2'd0, 32'h20, 32'h0, rd);
        check("lw_merged_word", rd, 32'hCDEF_AB78);
        do_req(1, 1'b1, 2'd1, 32'h23, 32'h0000_5555, rd);
        do_req(1, 1'b1, 2'd0, 32'h22, 32'hDEAD_BEEF, rd);
        do_req(1, 1'b0, 2'd0, 32'h20, 32'h0, rd);
        check("lw_after_misaligned", rd, 32'hCDEF_AB78);
        do_req(1, 1'b1, 2'd0, 32'h0000_1000, 32'hFFFF_FFFF, rd);
        do_req(1, 1'b1, 2'd3, 32'h24, 32'h1111_1111, rd);
        do_req(1, 1'b0, 2'd0, 32'h0, 32'h0, rd);
        check("lw_after_out_of_range", rd, 32'h0);
        do_req(1, 1'b0, 2'd0, 32'h0000_2000, 32'h0, rd);

        // Random traffic. Addresses stay mostly in a small window so that stores
        // and loads overlap; some addresses are out of range.
        for (int i = 0; i < 150; i++) begin
            w   = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
            do_req(1, w, sel, a, $urandom, rd);
        end

        // Back-to-back throughput with req_valid held high.
        held_loads(0);
        held_loads(2);

        // Reset during WAIT, in the middle of a store: no response and no write.
        @(negedge clk);
        req_valid_v[2] = 1'b1; we_v[2] = 1'b1; sel_v[2] = 2'd0;
        addr_v[2] = 32'h40; wdata_v[2] = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 req_valid_v[2] = 1'b0;
        @(negedge clk);
        check("mid_store_busy", 32'(busy_v[2]), 32'd1);
        rst_v[2] = 1'b0;
        #1;
        check("mid_reset_ready", 32'(req_ready_v[2]), 32'd1);
        model_clear(2);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_v[2]) pulses++;
            if (c == 2) rst_v[2] = 1'b1;
        end
        check("no_resp_after_reset", 32'(pulses), 32'd0);
        do_req(2, 1'b0, 2'd0, 32'h40, 32'h0, rd);
        check("lw_after_mid_reset", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
